ker_load_sched: RTL and testbench

Layer-level scheduler for the kernel SRAM write engine. It sequences one kernel group at a time: it configures the write engine's buffer length, starts a write pass into the 8 kernel SRAMs, waits for write completion, then hands the group to the PE array for compute. It sits between the schedule controller (layer start/done) and the kernel writer plus compute engine.

---
 rtl/ker_sched_pkg.sv | 19 +
 rtl/ker_load_sched_if.sv | 40 ++++
 rtl/ker_sched_wdog.sv | 30 +++
 rtl/ker_load_sched.sv | 124 ++++++++++++
 tb/tb_ker_load_sched.sv | 220 ++++++++++++++++++++++
 5 files changed

// File: rtl/ker_sched_pkg.sv
// Shared types and default widths for the kernel load scheduler.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package ker_sched_pkg;

  localparam int DEF_ADDR_CNT_BITS = 10;
  localparam int DEF_GRP_CNT_BITS  = 8;
  localparam int DEF_TO_BITS       = 16;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_WR_REQ  = 3'd1,
    S_WR_WAIT = 3'd2,
    S_CP_REQ  = 3'd3,
    S_CP_WAIT = 3'd4,
    S_DONE    = 3'd5
  } state_t;

endpackage

// File: rtl/ker_load_sched_if.sv
// Handshake bundle between the scheduler, the schedule controller, kernel writer and PE array.
// Latency: n/a (wires only).
// Backpressure: writer busy is the only stall input; everything else is one-cycle pulses.
interface ker_load_sched_if
  import ker_sched_pkg::*;
#(
  parameter int ADDR_CNT_BITS = DEF_ADDR_CNT_BITS,
  parameter int GRP_CNT_BITS  = DEF_GRP_CNT_BITS
);
  logic                     layer_start;
  logic [ADDR_CNT_BITS-1:0] cfg_ker_buflength;
  logic [GRP_CNT_BITS-1:0]  cfg_ker_groups;
  logic                     ker_write_start;
  logic [ADDR_CNT_BITS-1:0] cfg_kerw_buflength;
  logic                     ker_write_busy;
  logic                     ker_write_done;
  logic                     comp_start;
  logic                     comp_done;
  logic [GRP_CNT_BITS-1:0]  comp_group_idx;
  logic                     sched_busy;
  logic                     layer_done;
  logic                     err_timeout;

  // Scheduler side
  modport master (
    input  layer_start, cfg_ker_buflength, cfg_ker_groups,
    input  ker_write_busy, ker_write_done, comp_done,
    output ker_write_start, cfg_kerw_buflength, comp_start,
    output comp_group_idx, sched_busy, layer_done, err_timeout
  );

  // Controller / writer / PE array side
  modport slave (
    output layer_start, cfg_ker_buflength, cfg_ker_groups,
    output ker_write_busy, ker_write_done, comp_done,
    input  ker_write_start, cfg_kerw_buflength, comp_start,
    input  comp_group_idx, sched_busy, layer_done, err_timeout
  );

endinterface

// File: rtl/ker_sched_wdog.sv
// Watchdog counter: held at zero while clr, counts while en, flags expiry as it reaches all-ones.
// Latency: expire asserts on the 15th cycle (for 4 bits) of continuous enable after a clear.
// Backpressure: none.
module ker_sched_wdog #(
  parameter int TO_BITS = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic expire
);

  logic [TO_BITS-1:0] cnt;

  // Count wait cycles; saturate so a stuck enable cannot wrap back to a small value.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en && (cnt != '1)) begin
      cnt <= cnt + TO_BITS'(1);
    end
  end

  // Fires in the cycle whose closing edge would take the count to all-ones.
  assign expire = en && (cnt == ~TO_BITS'(1));

endmodule

// File: rtl/ker_load_sched.sv
// Kernel group scheduler: per group, start a kernel SRAM write pass, wait, then start compute.
// Latency: layer_start->write start 1 cycle; write done->comp_start 1; comp_done->next start/layer_done 1.
// Backpressure: holds the write start request while the writer is busy. Optional watchdog: KER_SCHED_TIMEOUT_EN.
module ker_load_sched
  import ker_sched_pkg::*;
#(
  parameter int ADDR_CNT_BITS = DEF_ADDR_CNT_BITS,
  parameter int GRP_CNT_BITS  = DEF_GRP_CNT_BITS,
  parameter int TO_BITS       = DEF_TO_BITS
) (
  input  logic             clk,
  input  logic             reset,
  ker_load_sched_if.master bus
);

  state_t                   state;
  logic [ADDR_CNT_BITS-1:0] len_q;
  logic [GRP_CNT_BITS-1:0]  grp_q;
  logic [GRP_CNT_BITS-1:0]  idx_q;
  logic                     cfg_zero;
  logic                     expire;

  // A zero length or zero group count is resolved in WR_REQ so no write is ever issued.
  assign cfg_zero = (len_q == '0) || (grp_q == '0);

`ifdef KER_SCHED_TIMEOUT_EN
  logic in_wait;
  logic err_q;

  assign in_wait = (state == S_WR_WAIT) || (state == S_CP_WAIT);

  ker_sched_wdog #(.TO_BITS(TO_BITS)) u_wdog (
    .clk    (clk),
    .reset  (reset),
    .clr    (!in_wait),
    .en     (in_wait),
    .expire (expire)
  );

  // Sticky timeout flag, cleared when a new layer is accepted.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_q <= 1'b0;
    end else if ((state == S_IDLE) && bus.layer_start) begin
      err_q <= 1'b0;
    end else if (expire) begin
      err_q <= 1'b1;
    end
  end

  assign bus.err_timeout = err_q;
`else
  // Width parameter kept for a uniform interface; no watchdog in this build.
  logic [TO_BITS-1:0] unused_to;
  assign unused_to       = '0;
  assign expire          = 1'b0;
  assign bus.err_timeout = 1'b0;
`endif

  // Layer sequencing FSM; configuration is captured only on an accepted start.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
      len_q <= '0;
      grp_q <= '0;
      idx_q <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.layer_start) begin
            len_q <= bus.cfg_ker_buflength;
            grp_q <= bus.cfg_ker_groups;
            idx_q <= '0;
            state <= S_WR_REQ;
          end
        end
        S_WR_REQ: begin
          if (cfg_zero) begin
            state <= S_DONE;
          end else if (!bus.ker_write_busy) begin
            state <= S_WR_WAIT;
          end
        end
        S_WR_WAIT: begin
          if (expire) begin
            state <= S_DONE;
          end else if (bus.ker_write_done) begin
            state <= S_CP_REQ;
          end
        end
        S_CP_REQ: begin
          state <= S_CP_WAIT;
        end
        S_CP_WAIT: begin
          if (expire) begin
            state <= S_DONE;
          end else if (bus.comp_done) begin
            if (idx_q == grp_q - GRP_CNT_BITS'(1)) begin
              state <= S_DONE;
            end else begin
              idx_q <= idx_q + GRP_CNT_BITS'(1);
              state <= S_WR_REQ;
            end
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  // Write start is qualified by busy in the same cycle the FSM leaves WR_REQ, so it is one cycle wide.
  assign bus.ker_write_start    = (state == S_WR_REQ) && !bus.ker_write_busy && !cfg_zero;
  assign bus.comp_start         = (state == S_CP_REQ);
  assign bus.layer_done         = (state == S_DONE);
  assign bus.sched_busy         = (state != S_IDLE);
  assign bus.comp_group_idx     = idx_q;
  assign bus.cfg_kerw_buflength = len_q;

endmodule

// File: tb/tb_ker_load_sched.sv
// Directed bench for ker_load_sched: vector table plus multi-cycle scenario sequences.
// Latency: n/a.
// Backpressure: exercised through ker_write_busy.
module tb_ker_load_sched;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  ker_load_sched_if #(.ADDR_CNT_BITS(10), .GRP_CNT_BITS(8)) bif ();

  ker_load_sched #(.ADDR_CNT_BITS(10), .GRP_CNT_BITS(8), .TO_BITS(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bif)
  );

  // {ws, cs, ld, sb, err, idx[7:0], blo[9:0]}
  logic [22:0] obs;
  assign obs = {bif.ker_write_start, bif.comp_start, bif.layer_done, bif.sched_busy,
                bif.err_timeout, bif.comp_group_idx, bif.cfg_kerw_buflength};

  typedef struct {
    logic       ls;
    logic [9:0] bl;
    logic [7:0] gr;
    logic       busy, wd, cd;
    logic       ws, cs, ld, sb;
    logic [7:0] idx;
    logic [9:0] blo;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  task automatic add(input logic ls, input int bl, input int gr, input logic busy, input logic wd,
                     input logic cd, input logic ws, input logic cs, input logic ld, input logic sb,
                     input int idx, input int blo);
    vec_t v;
    v.ls = ls; v.bl = 10'(bl); v.gr = 8'(gr); v.busy = busy; v.wd = wd; v.cd = cd;
    v.ws = ws; v.cs = cs; v.ld = ld; v.sb = sb; v.idx = 8'(idx); v.blo = 10'(blo);
    vecs.push_back(v);
  endtask

  task automatic drive(input logic ls, input logic [9:0] bl, input logic [7:0] gr,
                       input logic busy, input logic wd, input logic cd);
    bif.layer_start       = ls;
    bif.cfg_ker_buflength = bl;
    bif.cfg_ker_groups    = gr;
    bif.ker_write_busy    = busy;
    bif.ker_write_done    = wd;
    bif.comp_done         = cd;
  endtask

  task automatic do_reset();
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
  endtask

  // Runs one layer with a writer answering 5 cycles after each start and compute 4 cycles after
  // each comp_start. Stops at layer_done, or right after the comp_start of group stop_idx.
  task automatic run_layer(input logic [9:0] bl, input logic [7:0] gr, input int stop_idx,
                           output int nws, output int ncs, output int nld, output int ld_cyc,
                           output int cd_cyc, output int bl_bad, output int idx_bad);
    int wcnt;
    int ccnt;
    nws = 0; ncs = 0; nld = 0; ld_cyc = -1; cd_cyc = -1; bl_bad = 0; idx_bad = 0;
    wcnt = 0; ccnt = 0;
    for (int c = 0; c < 300; c++) begin
      @(posedge clk); #1;
      drive(c == 0, bl, gr, 1'b0, 1'b0, 1'b0);
      if (wcnt > 0) begin
        wcnt--;
        bif.ker_write_done = (wcnt == 0);
      end
      if (ccnt > 0) begin
        ccnt--;
        bif.comp_done = (ccnt == 0);
        if (ccnt == 0) cd_cyc = c;
      end
      @(negedge clk);
      if (c > 0 && bif.cfg_kerw_buflength !== bl) bl_bad++;
      if (bif.ker_write_start) begin
        nws++;
        wcnt = 5;
      end
      if (bif.comp_start) begin
        if (bif.comp_group_idx !== 8'(ncs)) idx_bad++;
        ncs++;
        ccnt = 4;
        if (int'(bif.comp_group_idx) == stop_idx) break;
      end
      if (bif.layer_done) begin
        nld++;
        ld_cyc = c;
        break;
      end
    end
    drive(1'b0, 10'd0, 8'd0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    int nws, ncs, nld, ld_cyc, cd_cyc, bl_bad, idx_bad;
    int rise, ld_at;

    reset = 1'b1;
    drive(1'b0, 10'd0, 8'd0, 1'b0, 1'b0, 1'b0);
    #1 chk("reset_state", 32'(obs), 32'd0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    //   ls  bl   gr  busy wd cd | ws cs ld sb idx blo
    add(1'b0, 0,   0, 0, 0, 0,    0, 0, 0, 0, 0,  0);   // idle after reset
    add(1'b1, 50,  0, 0, 0, 0,    0, 0, 0, 0, 0,  0);   // groups = 0
    add(1'b0, 0,   0, 0, 0, 0,    0, 0, 0, 1, 0,  50);
    add(1'b0, 0,   0, 0, 0, 0,    0, 0, 1, 1, 0,  50);  // layer_done at t+2
    add(1'b0, 0,   0, 0, 0, 0,    0, 0, 0, 0, 0,  50);
    add(1'b1, 0,   2, 0, 0, 0,    0, 0, 0, 0, 0,  50);  // buflength = 0
    add(1'b0, 0,   0, 0, 0, 0,    0, 0, 0, 1, 0,  0);
    add(1'b1, 9,   1, 0, 0, 0,    0, 0, 1, 1, 0,  0);   // start during DONE ignored
    add(1'b0, 0,   0, 0, 0, 0,    0, 0, 0, 0, 0,  0);
    add(1'b1, 7,   2, 0, 0, 0,    0, 0, 0, 0, 0,  0);   // two-group layer
    add(1'b0, 0,   0, 0, 0, 0,    1, 0, 0, 1, 0,  7);
    add(1'b1, 100, 5, 0, 0, 1,    0, 0, 0, 1, 0,  7);   // comp_done + restart in WR_WAIT ignored
    add(1'b0, 0,   0, 0, 1, 0,    0, 0, 0, 1, 0,  7);
    add(1'b0, 0,   0, 0, 0, 0,    0, 1, 0, 1, 0,  7);
    add(1'b0, 0,   0, 0, 1, 0,    0, 0, 0, 1, 0,  7);   // write done in CP_WAIT ignored
    add(1'b0, 0,   0, 0, 0, 1,    0, 0, 0, 1, 0,  7);
    add(1'b0, 0,   0, 1, 0, 0,    0, 0, 0, 1, 1,  7);   // writer busy holds start
    add(1'b0, 0,   0, 0, 0, 0,    1, 0, 0, 1, 1,  7);
    add(1'b0, 0,   0, 0, 1, 0,    0, 0, 0, 1, 1,  7);
    add(1'b0, 0,   0, 0, 0, 0,    0, 1, 0, 1, 1,  7);
    add(1'b0, 0,   0, 0, 0, 1,    0, 0, 0, 1, 1,  7);
    add(1'b0, 0,   0, 0, 0, 0,    0, 0, 1, 1, 1,  7);
    add(1'b0, 0,   0, 0, 0, 0,    0, 0, 0, 0, 1,  7);

    for (int i = 0; i < vecs.size(); i++) begin
      @(posedge clk); #1;
      drive(vecs[i].ls, vecs[i].bl, vecs[i].gr, vecs[i].busy, vecs[i].wd, vecs[i].cd);
      @(negedge clk);
      chk($sformatf("vec%0d", i), 32'(obs),
          32'({vecs[i].ws, vecs[i].cs, vecs[i].ld, vecs[i].sb, 1'b0, vecs[i].idx, vecs[i].blo}));
    end

    // Writer busy for the first 6 cycles of the layer: single start exactly when busy drops.
    for (int c = 0; c < 8; c++) begin
      @(posedge clk); #1;
      drive(c == 0, 10'd20, 8'd1, c < 6, 1'b0, 1'b0);
      @(negedge clk);
      chk($sformatf("busy_ws_c%0d", c), 32'(bif.ker_write_start), 32'(c == 6));
    end
    drive(1'b0, 10'd0, 8'd0, 1'b0, 1'b0, 1'b0);
    do_reset();

    // Nominal three-group layer.
    run_layer(10'd288, 8'd3, -1, nws, ncs, nld, ld_cyc, cd_cyc, bl_bad, idx_bad);
    chk("nom_write_starts", 32'(nws), 32'd3);
    chk("nom_comp_starts", 32'(ncs), 32'd3);
    chk("nom_idx_seq", 32'(idx_bad), 32'd0);
    chk("nom_buflength", 32'(bl_bad), 32'd0);
    chk("nom_layer_done", 32'(nld), 32'd1);
    chk("nom_done_latency", 32'(ld_cyc - cd_cyc), 32'd1);

    // Asynchronous reset in CP_WAIT of group 1.
    run_layer(10'd288, 8'd3, 1, nws, ncs, nld, ld_cyc, cd_cyc, bl_bad, idx_bad);
    chk("rst_reached_grp1", 32'(ncs), 32'd2);
    @(posedge clk); #1;
    chk("rst_pre_busy", 32'(bif.sched_busy), 32'd1);
    #1 reset = 1'b1;
    #1 chk("rst_async_outputs", 32'(obs), 32'd0);
    @(posedge clk); #1 reset = 1'b0;
    nld = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (bif.layer_done) nld++;
    end
    chk("rst_no_layer_done", 32'(nld), 32'd0);
    run_layer(10'd5, 8'd1, -1, nws, ncs, nld, ld_cyc, cd_cyc, bl_bad, idx_bad);
    chk("rst_restart_ws", 32'(nws), 32'd1);
    chk("rst_restart_idx", 32'(idx_bad), 32'd0);
    chk("rst_restart_done", 32'(nld), 32'd1);

`ifdef KER_SCHED_TIMEOUT_EN
    // Writer never completes: WR_WAIT entered at c2, timeout 15 cycles later.
    rise = -1;
    ld_at = -1;
    for (int c = 0; c < 24; c++) begin
      @(posedge clk); #1;
      drive(c == 0 || c == 19, 10'd4, 8'd1, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      if (bif.err_timeout && rise < 0) rise = c;
      if (bif.layer_done && ld_at < 0) ld_at = c;
      if (c == 19) chk("wdog_err_held", 32'(bif.err_timeout), 32'd1);
      if (c == 20) chk("wdog_err_clear", 32'(bif.err_timeout), 32'd0);
    end
    chk("wdog_err_rise", 32'(rise), 32'd17);
    chk("wdog_layer_done", 32'(ld_at), 32'd17);
    drive(1'b0, 10'd0, 8'd0, 1'b0, 1'b0, 1'b0);
    do_reset();
`else
    rise = 0;
    ld_at = 0;
    chk("err_timeout_zero", 32'(bif.err_timeout), 32'(rise + ld_at));
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
